// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO multiply/divide coprocessor: iterative shift-add multiply and restoring divide,
// one bit per cycle, with MT/MF interlocked against an operation in flight.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  mul__opcode_2a,
  input  logic             mul__active_2a,
  input  logic [WIDTH-1:0] rs_data_2a,
  input  logic [WIDTH-1:0] rt_data_2a,
  output logic [WIDTH-1:0] mul__rd_data_3a,
  output logic             mul__stall_2a
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(1);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(7);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q, rd_q;
  logic [WIDTH-1:0]   a_q, rs_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q, rneg_q, dz_q, is_div_q;

  function automatic logic [WIDTH-1:0] mag_w(input logic signed [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic accept, start_mul, start_div, sgn_op;
  assign mul__stall_2a   = mul__active_2a & busy_q;
  assign accept          = mul__active_2a & ~busy_q;
  assign start_mul       = accept & ((mul__opcode_2a == OP_MULT) | (mul__opcode_2a == OP_MULTU));
  assign start_div       = accept & ((mul__opcode_2a == OP_DIV)  | (mul__opcode_2a == OP_DIVU));
  assign sgn_op          = (mul__opcode_2a == OP_MULT) | (mul__opcode_2a == OP_DIV);
  assign mul__rd_data_3a = rd_q;

  // One iteration step: multiply adds into the upper half then shifts right;
  // divide shifts the {remainder,quotient} pair left and keeps a non-negative trial.
  logic [WIDTH:0]     msum, dtrial;
  logic [2*WIDTH:0]   dsh;
  logic [2*WIDTH-1:0] mul_next, div_next, fix_res;
  always_comb begin
    msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {msum, acc_q[WIDTH-1:1]};
    dsh      = {acc_q, 1'b0};
    dtrial   = dsh[2*WIDTH:WIDTH] - {1'b0, a_q};
    div_next = dtrial[WIDTH] ? dsh[2*WIDTH-1:0] : {dtrial[WIDTH-1:0], dsh[WIDTH-1:1], 1'b1};
    if (dz_q)          fix_res = {rs_q, {WIDTH{1'b1}}};
    else if (is_div_q) fix_res = {cneg_w(acc_q[2*WIDTH-1:WIDTH], rneg_q), cneg_w(acc_q[WIDTH-1:0], neg_q)};
    else               fix_res = cneg_2w(acc_q, neg_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_mul) state_d = S_MUL; else if (start_div) state_d = S_DIV;
      S_MUL, S_DIV: if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      S_FIX: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control and architectural state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= (state_q == S_MUL || state_q == S_DIV) ? cnt_q + 1'b1 : '0;
      if (accept) begin
        if (mul__opcode_2a == OP_MTHI) hi_q <= rs_data_2a;
        if (mul__opcode_2a == OP_MTLO) lo_q <= rs_data_2a;
        if (mul__opcode_2a == OP_MFHI) rd_q <= hi_q;
        if (mul__opcode_2a == OP_MFLO) rd_q <= lo_q;
      end
      if (state_q == S_FIX) {hi_q, lo_q} <= fix_res;
    end
  end

  // Iteration datapath; only meaningful while an operation is in flight
  always_ff @(posedge clk) begin
    if (start_mul || start_div) begin
      a_q      <= mag_w(rt_data_2a, sgn_op);
      acc_q    <= {{WIDTH{1'b0}}, mag_w(rs_data_2a, sgn_op)};
      rs_q     <= rs_data_2a;
      neg_q    <= sgn_op & (rs_data_2a[WIDTH-1] ^ rt_data_2a[WIDTH-1]);
      rneg_q   <= sgn_op & rs_data_2a[WIDTH-1];
      dz_q     <= start_div & (rt_data_2a == '0);
      is_div_q <= start_div;
    end else if (state_q == S_MUL) begin
      acc_q <= mul_next;
    end else if (state_q == S_DIV) begin
      acc_q <= div_next;
    end
  end
endmodule
